ddr2_local_arbiter: RTL and testbench

DDR2_LOCAL_ARBITER -- requirements
Module: ddr2_local_arbiter
Interface
REQ-001 Parameter ADDR_W, default 24, is the local address width in words.
REQ-002 Parameter DATA_W, default 64, is the local data width; local_be width is DATA_W/8.
REQ-003 Parameter MAX_RD_OUT, default 8, is the maximum number of read beats outstanding, range 1..15.
REQ-004 phy_clk  in  1  is the single clock; all logic is rising-edge.
REQ-005 reset_phy_clk_n  in  1  is the reset: synchronous, active-low.
REQ-006 local_init_done  in  1  is the controller calibration-complete flag.
REQ-007 local_ready  in  1  is controller accept; a beat or command transfers on a cycle with local_ready=1.
REQ-008 local_rdata_valid  in  1  marks one read beat returned by the controller.
REQ-009 local_rdata  in  DATA_W  is the read beat data.
REQ-010 local_address  out  ADDR_W  is the command address.
REQ-011 local_size  out  4  is the burst length in beats, 1..8.
REQ-012 local_burstbegin  out  1  marks the first beat of a write burst and every read command.
REQ-013 local_write_req  out  1  is the write beat request.
REQ-014 local_read_req  out  1  is the read command request.
REQ-015 local_wdata  out  DATA_W  is the write beat data.
REQ-016 local_be  out  DATA_W/8  is the byte enable, constant all-ones.
REQ-017 wr_req  in  1  is the write requester request; it is held until wr_grant and is raised only when the full burst data is available.
REQ-018 wr_addr  in  ADDR_W  is the write address, stable while wr_req=1.
REQ-019 wr_size  in  4  is the write burst length, stable while wr_req=1.
REQ-020 wr_data  in  DATA_W  is the current write beat, presented first-word-fall-through.
REQ-021 wr_data_ack  out  1  pops one write beat from the source.
REQ-022 wr_grant  out  1  is a one-cycle pulse on acceptance of the last write beat.
REQ-023 rd_req  in  1  is the read requester request; it is held until rd_grant.
REQ-024 rd_addr  in  ADDR_W  is the read address, stable while rd_req=1.
REQ-025 rd_size  in  4  is the read burst length, stable while rd_req=1.
REQ-026 rd_grant  out  1  is a one-cycle pulse on acceptance of the read command.
REQ-027 rd_data  out  DATA_W  is local_rdata passed through combinationally.
REQ-028 rd_data_valid  out  1  is local_rdata_valid passed through combinationally.
Function
REQ-029 The FSM SHALL use the states IDLE, WR_BURST and RD_CMD; IDLE is left only when local_init_done=1.
REQ-030 In IDLE, a single pending request SHALL be taken; with both pending, the requester not served last SHALL be taken (round-robin via a last_grant register).
REQ-031 A read SHALL be eligible only when rd_out + eff_rd_size <= MAX_RD_OUT, where eff_size = (size==0) ? 1 : size; otherwise a pending write is taken or the FSM holds in IDLE.
REQ-032 On leaving IDLE, the address and eff_size SHALL be latched, so the local_* request rises exactly 1 cycle after the request is sampled in IDLE.
REQ-033 In WR_BURST, local_write_req=1, local_wdata=wr_data and local_burstbegin=(beat_cnt==0); wr_data_ack=local_ready, and beat_cnt increments on each accepted beat.
REQ-034 When the beat at beat_cnt==size-1 is accepted, the block SHALL pulse wr_grant, clear beat_cnt, return to IDLE and set last_grant=WR.
REQ-035 In RD_CMD, local_read_req=1 and local_burstbegin=1 are held until local_ready; on acceptance the block SHALL pulse rd_grant, set last_grant=RD and return to IDLE.
REQ-036 rd_out (4 bits) SHALL add eff_size on read acceptance and subtract 1 on each local_rdata_valid; both events in the same cycle SHALL give rd_out+size-1, and the decrement SHALL saturate at 0.
REQ-037 Every command SHALL be followed by one IDLE cycle, and local_address and local_size SHALL stay constant while local_ready=0.
REQ-038 If local_init_done falls mid-operation, the current burst or command SHALL complete and no new grant SHALL be issued.
Reset
REQ-039 With reset_phy_clk_n=0 at a rising edge: state=IDLE, beat_cnt=0, rd_out=0, last_grant=RD (write wins the first tie), and all local_*_req, local_burstbegin, wr_data_ack, wr_grant and rd_grant = 0; reset mid-burst SHALL abandon the burst, and rd_data_valid SHALL still pass through.
Structure
REQ-040 Package ddr2_arb_pkg SHALL hold the state enum, the last_grant encoding and the SIZE_W=4 and MAX_BURST=8 constants.
REQ-041 Sub-module ddr2_rd_credit SHALL implement rd_out and the eligibility compare; all other logic SHALL be flat.
Verification
REQ-042 Write only: wr_size=4, local_ready=1 -> local_write_req high for 4 cycles, burstbegin on beat 0 only, 4 wr_data_ack, wr_grant on beat 4.
REQ-043 wr_req and rd_req raised in the same cycle after reset -> write served first, then read; repeat -> alternation WR, RD, WR, RD.
REQ-044 MAX_RD_OUT=8, two reads of size 8 with no rdata_valid -> second read is blocked; after 1 rdata_valid it is still blocked; after 8 it is granted.
REQ-045 local_ready=0 for 3 cycles during write beat 2 -> wdata, address and size are held, with no wr_data_ack during the stall.
REQ-046 Reset asserted during beat 2 of an 8-beat write -> next cycle IDLE with all requests low, and rd_out=0 with no underflow on later rdata_valid.

---
 rtl/ddr2_arb_pkg.sv | 26 ++
 rtl/ddr2_local_arbiter_if.sv | 63 ++++++
 rtl/ddr2_rd_credit.sv | 38 +++
 rtl/ddr2_local_arbiter.sv | 128 ++++++++++++
 tb/tb_ddr2_local_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr2_arb_pkg.sv
// Shared types and constants for the DDR2 local-port arbiter.
// Covers the FSM state encoding, the last-grant encoding and the burst sizing helper.
package ddr2_arb_pkg;

   localparam int SIZE_W    = 4;
   localparam int MAX_BURST = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_CMD   = 2'd2
   } state_e;

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_e;

   // A size of 0 is treated as a single beat; oversize requests are clamped to the max burst.
   function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] size);
      if (size == '0) return SIZE_W'(1);
      if (size > SIZE_W'(MAX_BURST)) return SIZE_W'(MAX_BURST);
      return size;
   endfunction

endpackage

// File: rtl/ddr2_local_arbiter_if.sv
// Bundle of controller-side, requester-side and debug signals of the arbiter.
// master = arbiter view, slave = environment (controller + requesters) view.
interface ddr2_local_arbiter_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 64
);
   import ddr2_arb_pkg::*;

   // Handshake: a beat or command transfers on any cycle where the arbiter holds
   // local_write_req/local_read_req and local_ready=1; until then address, size and
   // data stay stable. Requesters hold wr_req/rd_req until their one-cycle grant.
   logic                  local_init_done;
   logic                  local_ready;
   logic                  local_rdata_valid;
   logic [DATA_W-1:0]     local_rdata;
   logic [ADDR_W-1:0]     local_address;
   logic [SIZE_W-1:0]     local_size;
   logic                  local_burstbegin;
   logic                  local_write_req;
   logic                  local_read_req;
   logic [DATA_W-1:0]     local_wdata;
   logic [DATA_W/8-1:0]   local_be;

   logic                  wr_req;
   logic [ADDR_W-1:0]     wr_addr;
   logic [SIZE_W-1:0]     wr_size;
   logic [DATA_W-1:0]     wr_data;
   logic                  wr_data_ack;
   logic                  wr_grant;

   logic                  rd_req;
   logic [ADDR_W-1:0]     rd_addr;
   logic [SIZE_W-1:0]     rd_size;
   logic                  rd_grant;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_data_valid;

   state_e                dbg_state;
   logic [SIZE_W-1:0]     dbg_rd_out;

   modport master (
      input  local_init_done, local_ready, local_rdata_valid, local_rdata,
      output local_address, local_size, local_burstbegin, local_write_req,
      output local_read_req, local_wdata, local_be,
      input  wr_req, wr_addr, wr_size, wr_data,
      output wr_data_ack, wr_grant,
      input  rd_req, rd_addr, rd_size,
      output rd_grant, rd_data, rd_data_valid,
      output dbg_state, dbg_rd_out
   );

   modport slave (
      output local_init_done, local_ready, local_rdata_valid, local_rdata,
      input  local_address, local_size, local_burstbegin, local_write_req,
      input  local_read_req, local_wdata, local_be,
      output wr_req, wr_addr, wr_size, wr_data,
      input  wr_data_ack, wr_grant,
      output rd_req, rd_addr, rd_size,
      input  rd_grant, rd_data, rd_data_valid,
      input  dbg_state, dbg_rd_out
   );

endinterface

// File: rtl/ddr2_rd_credit.sv
// Outstanding read-beat counter and read eligibility compare.
// Adds a burst on command acceptance, removes one per returned beat, never below zero.
module ddr2_rd_credit
   import ddr2_arb_pkg::*;
#(
   parameter int MAX_RD_OUT = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              rd_accept_i,
   input  logic [SIZE_W-1:0] accept_size_i,
   input  logic              rdata_valid_i,
   input  logic [SIZE_W-1:0] req_size_i,
   output logic              rd_ok_o,
   output logic [SIZE_W-1:0] rd_out_o
);

   localparam int CW = SIZE_W + 1;

   logic [SIZE_W-1:0] rd_out_q, rd_out_d;
   logic [CW-1:0]     rd_sum;

   always_comb begin
      rd_sum = {1'b0, rd_out_q};
      if (rd_accept_i) rd_sum = rd_sum + {1'b0, accept_size_i};
      if (rdata_valid_i && (rd_sum != '0)) rd_sum = rd_sum - CW'(1);
      rd_out_d = rd_sum[SIZE_W-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) rd_out_q <= '0;
      else          rd_out_q <= rd_out_d;
   end

   assign rd_ok_o  = (({1'b0, rd_out_q} + {1'b0, req_size_i}) <= CW'(MAX_RD_OUT));
   assign rd_out_o = rd_out_q;

endmodule

// File: rtl/ddr2_local_arbiter.sv
// Round-robin arbiter between one write and one read requester onto the DDR2
// controller local port; write bursts stream beats, reads issue a single command.
module ddr2_local_arbiter
   import ddr2_arb_pkg::*;
#(
   parameter int ADDR_W     = 24,
   parameter int DATA_W     = 64,
   parameter int MAX_RD_OUT = 8
) (
   input logic                 phy_clk,
   input logic                 reset_phy_clk_n,
   ddr2_local_arbiter_if.master bus
);

   localparam int BE_W = DATA_W / 8;

   state_e            state_q, state_d;
   grant_e            last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SIZE_W-1:0] size_q, size_d;
   logic [SIZE_W-1:0] beat_cnt_q, beat_cnt_d;

   logic [SIZE_W-1:0] wr_eff, rd_eff, rd_out;
   logic              rd_ok, rd_accept;
   logic              wr_pend, rd_pend, wr_take, rd_take;

   assign wr_eff    = eff_size(bus.wr_size);
   assign rd_eff    = eff_size(bus.rd_size);
   assign rd_accept = (state_q == RD_CMD) && bus.local_ready;

   ddr2_rd_credit #(.MAX_RD_OUT(MAX_RD_OUT)) u_rd_credit (
      .clk_i         (phy_clk),
      .rst_n_i       (reset_phy_clk_n),
      .rd_accept_i   (rd_accept),
      .accept_size_i (size_q),
      .rdata_valid_i (bus.local_rdata_valid),
      .req_size_i    (rd_eff),
      .rd_ok_o       (rd_ok),
      .rd_out_o      (rd_out)
   );

   // On a tie the requester not served last wins; a read blocked by credit yields.
   always_comb begin
      wr_pend = bus.local_init_done && bus.wr_req;
      rd_pend = bus.local_init_done && bus.rd_req && rd_ok;
      wr_take = wr_pend && (!rd_pend || (last_grant_q == GRANT_RD));
      rd_take = rd_pend && !wr_take;
   end

   always_comb begin
      state_d              = state_q;
      last_grant_d         = last_grant_q;
      addr_d               = addr_q;
      size_d               = size_q;
      beat_cnt_d           = beat_cnt_q;
      bus.local_write_req  = 1'b0;
      bus.local_read_req   = 1'b0;
      bus.local_burstbegin = 1'b0;
      bus.local_wdata      = bus.wr_data;
      bus.wr_data_ack      = 1'b0;
      bus.wr_grant         = 1'b0;
      bus.rd_grant         = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_take) begin
               state_d    = WR_BURST;
               addr_d     = bus.wr_addr;
               size_d     = wr_eff;
               beat_cnt_d = '0;
            end else if (rd_take) begin
               state_d = RD_CMD;
               addr_d  = bus.rd_addr;
               size_d  = rd_eff;
            end
         end
         WR_BURST: begin
            bus.local_write_req  = 1'b1;
            bus.local_burstbegin = (beat_cnt_q == '0);
            bus.wr_data_ack      = bus.local_ready;
            if (bus.local_ready) begin
               if (beat_cnt_q == size_q - SIZE_W'(1)) begin
                  bus.wr_grant = 1'b1;
                  beat_cnt_d   = '0;
                  last_grant_d = GRANT_WR;
                  state_d      = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + SIZE_W'(1);
               end
            end
         end
         RD_CMD: begin
            bus.local_read_req   = 1'b1;
            bus.local_burstbegin = 1'b1;
            if (bus.local_ready) begin
               bus.rd_grant = 1'b1;
               last_grant_d = GRANT_RD;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge phy_clk) begin
      if (!reset_phy_clk_n) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_RD;
         addr_q       <= '0;
         size_q       <= '0;
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   assign bus.local_address = addr_q;
   assign bus.local_size    = size_q;
   assign bus.local_be      = {BE_W{1'b1}};
   assign bus.rd_data       = bus.local_rdata;
   assign bus.rd_data_valid = bus.local_rdata_valid;
   assign bus.dbg_state     = state_q;
   assign bus.dbg_rd_out    = rd_out;

endmodule

// File: tb/tb_ddr2_local_arbiter.sv
// Self-checking bench for ddr2_local_arbiter: transaction table plus directed
// sequences for arbitration, read credit, stalls, init_done loss and reset.
module tb_ddr2_local_arbiter;
   import ddr2_arb_pkg::*;

   localparam int AW    = 24;
   localparam int DW    = 64;
   localparam int MAXRD = 8;
   localparam int NV    = 8;

   typedef struct {
      logic          is_rd;
      logic [AW-1:0] addr;
      logic [3:0]    size;
      logic [3:0]    exp_size;
   } vec_t;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ddr2_local_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ddr2_local_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RD_OUT(MAXRD)) dut (
      .phy_clk         (clk),
      .reset_phy_clk_n (rst_n),
      .bus             (bus)
   );

   // scoreboard and statistics
   logic [AW+4+DW-1:0] exp_wq[$];
   logic [AW+3:0]      exp_rq[$];
   int grant_log[$];
   int n_cmp = 0, n_err = 0, cyc = 0;
   int n_wreq, n_bb, n_ack, n_wgrant, n_rgrant;
   int first_wreq, first_rreq, last_ack_cyc, wgrant_cyc;
   logic [DW-1:0] wr_base = '0;
   int   wr_beat = 0;
   logic rand_ready = 1'b0;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int glog(input int i);
      return (i < grant_log.size()) ? grant_log[i] : 9;
   endfunction

   task automatic clear_stats();
      n_wreq = 0; n_bb = 0; n_ack = 0; n_wgrant = 0; n_rgrant = 0;
      first_wreq = -1; first_rreq = -1; last_ack_cyc = -1; wgrant_cyc = -1;
      grant_log.delete();
   endtask

   // One clock cycle: sample at negedge+2, then advance to the next negedge and drive.
   task automatic tick();
      logic wr_drop, rd_drop;
      wr_drop = 1'b0;
      rd_drop = 1'b0;
      #2;
      if (bus.local_rdata_valid)
         check("rd_pass", {bus.rd_data_valid, bus.rd_data}, {1'b1, bus.local_rdata});
      if (rst_n) begin
         if (bus.local_ready && bus.local_write_req) begin
            if (exp_wq.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL sb_wr: unexpected beat addr %0h data %0h", bus.local_address, bus.local_wdata);
            end else check("sb_wr", {bus.local_address, bus.local_size, bus.local_wdata}, exp_wq.pop_front());
         end
         if (bus.local_ready && bus.local_read_req) begin
            if (exp_rq.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL sb_rd: unexpected read addr %0h", bus.local_address);
            end else check("sb_rd", {bus.local_address, bus.local_size}, exp_rq.pop_front());
         end
         if (bus.local_write_req) begin
            n_wreq++;
            if (first_wreq < 0) first_wreq = cyc;
         end
         if (bus.local_read_req && first_rreq < 0) first_rreq = cyc;
         if (bus.local_burstbegin && bus.local_ready) n_bb++;
         if (bus.wr_data_ack) begin n_ack++; last_ack_cyc = cyc; wr_beat++; end
         if (bus.wr_grant) begin n_wgrant++; wgrant_cyc = cyc; grant_log.push_back(0); wr_drop = 1'b1; end
         if (bus.rd_grant) begin n_rgrant++; grant_log.push_back(1); rd_drop = 1'b1; end
      end
      @(negedge clk);
      cyc++;
      if (wr_drop) bus.wr_req = 1'b0;
      if (rd_drop) bus.rd_req = 1'b0;
      bus.wr_data = wr_base + DW'(wr_beat);
      if (rand_ready) bus.local_ready = ($urandom_range(0, 3) != 0);
   endtask

   // driver tasks
   task automatic start_wr(input logic [AW-1:0] a, input logic [3:0] s, input logic [3:0] es);
      wr_base = {32'($urandom), 32'($urandom)};
      wr_beat = 0;
      bus.wr_addr = a; bus.wr_size = s; bus.wr_data = wr_base; bus.wr_req = 1'b1;
      for (int i = 0; i < int'(es); i++) exp_wq.push_back({a, es, wr_base + DW'(i)});
   endtask

   task automatic start_rd(input logic [AW-1:0] a, input logic [3:0] s, input logic [3:0] es);
      bus.rd_addr = a; bus.rd_size = s; bus.rd_req = 1'b1;
      exp_rq.push_back({a, es});
   endtask

   task automatic wait_reqs_done(input int bound, input string name);
      for (int n = 0; n < bound && (bus.wr_req || bus.rd_req); n++) tick();
      check(name, {bus.wr_req, bus.rd_req}, 2'b00);
      tick();
   endtask

   task automatic pulse_rvalid(input int n);
      for (int i = 0; i < n; i++) begin
         bus.local_rdata_valid = 1'b1;
         bus.local_rdata = {32'($urandom), 32'($urandom)};
         tick();
      end
      bus.local_rdata_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      vecs[0] = '{1'b0, 24'h001000, 4'd1, 4'd1};
      vecs[1] = '{1'b0, 24'h002000, 4'd4, 4'd4};
      vecs[2] = '{1'b0, 24'h003000, 4'd8, 4'd8};
      vecs[3] = '{1'b0, 24'h004000, 4'd0, 4'd1};
      vecs[4] = '{1'b1, 24'h005000, 4'd1, 4'd1};
      vecs[5] = '{1'b1, 24'h006000, 4'd8, 4'd8};
      vecs[6] = '{1'b1, 24'h007000, 4'd0, 4'd1};
      vecs[7] = '{1'b0, 24'h008000, 4'd3, 4'd3};

      bus.local_init_done = 1'b0; bus.local_ready = 1'b1;
      bus.local_rdata_valid = 1'b0; bus.local_rdata = '0;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_size = '0; bus.wr_data = '0;
      bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_size = '0;
      clear_stats();
      @(negedge clk);
      tick(); tick();

      // reset state
      #1;
      check("rst_state", bus.dbg_state, IDLE);
      check("rst_wreq", bus.local_write_req, 1'b0);
      check("rst_rreq", bus.local_read_req, 1'b0);
      check("rst_bb", bus.local_burstbegin, 1'b0);
      check("rst_ack", bus.wr_data_ack, 1'b0);
      check("rst_grants", {bus.wr_grant, bus.rd_grant}, 2'b00);
      check("rst_rd_out", bus.dbg_rd_out, 4'd0);
      check("rst_be", bus.local_be, 8'hFF);
      check("rst_rvalid", bus.rd_data_valid, 1'b0);

      // simultaneous requests after reset: write first, then read, twice
      rst_n = 1'b1;
      bus.local_init_done = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         clear_stats();
         c0 = cyc;
         start_wr(24'h010000 + AW'(rep), 4'd2, 4'd2);
         start_rd(24'h020000 + AW'(rep), 4'd1, 4'd1);
         wait_reqs_done(30, "tie_timeout");
         check("tie_first_wr", glog(0), 0);
         check("tie_second_rd", glog(1), 1);
         check("tie_wgrant_cyc", wgrant_cyc, c0 + 2);
         check("tie_idle_gap", first_rreq, c0 + 4);
         pulse_rvalid(1);
      end

      // single 4-beat write with ready held high
      clear_stats();
      c0 = cyc;
      start_wr(24'h0ABCDE, 4'd4, 4'd4);
      wait_reqs_done(20, "wr4_timeout");
      check("wr4_latency", first_wreq, c0 + 1);
      check("wr4_req_cycles", n_wreq, 4);
      check("wr4_bb", n_bb, 1);
      check("wr4_acks", n_ack, 4);
      check("wr4_last_ack", last_ack_cyc, c0 + 4);
      check("wr4_grant_cyc", wgrant_cyc, c0 + 4);

      // after a write, a tie goes to the read
      clear_stats();
      start_rd(24'h030000, 4'd1, 4'd1);
      start_wr(24'h031000, 4'd1, 4'd1);
      wait_reqs_done(30, "rr_timeout");
      check("rr_first_rd", glog(0), 1);
      check("rr_second_wr", glog(1), 0);
      pulse_rvalid(1);
      check("rr_rd_out", bus.dbg_rd_out, 4'd0);

      // transaction table under random ready back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         clear_stats();
         if (vecs[i].is_rd) start_rd(vecs[i].addr, vecs[i].size, vecs[i].exp_size);
         else               start_wr(vecs[i].addr, vecs[i].size, vecs[i].exp_size);
         wait_reqs_done(80, "tbl_timeout");
         check("tbl_bb", n_bb, 1);
         if (vecs[i].is_rd) begin
            check("tbl_rgrant", n_rgrant, 1);
            pulse_rvalid(int'(vecs[i].exp_size));
            check("tbl_rd_drain", bus.dbg_rd_out, 4'd0);
         end else begin
            check("tbl_acks", n_ack, int'(vecs[i].exp_size));
            check("tbl_wgrant", n_wgrant, 1);
         end
      end
      rand_ready = 1'b0;
      bus.local_ready = 1'b1;

      // read credit: second 8-beat read blocked until all 8 beats return
      clear_stats();
      start_rd(24'h040000, 4'd8, 4'd8);
      wait_reqs_done(20, "cr_rd1_timeout");
      check("cr_rd_out_8", bus.dbg_rd_out, 4'd8);
      clear_stats();
      start_rd(24'h041000, 4'd8, 4'd8);
      start_wr(24'h042000, 4'd2, 4'd2);
      for (int n = 0; n < 20 && bus.wr_req; n++) tick();
      check("cr_wr_served", n_wgrant, 1);
      check("cr_rd_blocked", n_rgrant, 0);
      pulse_rvalid(1);
      repeat (3) tick();
      check("cr_rd_out_7", bus.dbg_rd_out, 4'd7);
      check("cr_still_blocked", n_rgrant, 0);
      pulse_rvalid(7);
      wait_reqs_done(20, "cr_rd2_timeout");
      check("cr_rd_granted", n_rgrant, 1);
      check("cr_rd_out_again", bus.dbg_rd_out, 4'd8);
      pulse_rvalid(8);
      check("cr_drained", bus.dbg_rd_out, 4'd0);

      // read acceptance and a returned beat in the same cycle, then saturation at 0
      clear_stats();
      start_rd(24'h050000, 4'd3, 4'd3);
      tick();
      bus.local_rdata_valid = 1'b1;
      tick();
      bus.local_rdata_valid = 1'b0;
      check("both_rd_out", bus.dbg_rd_out, 4'd2);
      check("both_rgrant", n_rgrant, 1);
      pulse_rvalid(2);
      check("both_drained", bus.dbg_rd_out, 4'd0);
      pulse_rvalid(2);
      check("rd_out_sat", bus.dbg_rd_out, 4'd0);

      // 3-cycle stall on write beat 2
      clear_stats();
      start_wr(24'h060000, 4'd4, 4'd4);
      for (int n = 0; n < 10 && n_ack < 2; n++) tick();
      bus.local_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         check("stall_wreq", bus.local_write_req, 1'b1);
         check("stall_wdata", bus.local_wdata, wr_base + 64'd2);
         check("stall_addr_size", {bus.local_address, bus.local_size}, {24'h060000, 4'd4});
         check("stall_no_ack", bus.wr_data_ack, 1'b0);
         tick();
      end
      bus.local_ready = 1'b1;
      wait_reqs_done(20, "stall_timeout");
      check("stall_acks", n_ack, 4);
      check("stall_wgrant", n_wgrant, 1);

      // init_done lost mid-burst: burst completes, no new grant until it returns
      clear_stats();
      start_wr(24'h070000, 4'd4, 4'd4);
      for (int n = 0; n < 10 && n_ack < 1; n++) tick();
      bus.local_init_done = 1'b0;
      start_rd(24'h071000, 4'd1, 4'd1);
      for (int n = 0; n < 20 && bus.wr_req; n++) tick();
      repeat (5) tick();
      check("init_wr_done", n_wgrant, 1);
      check("init_no_rd", n_rgrant, 0);
      check("init_idle", bus.dbg_state, IDLE);
      bus.local_init_done = 1'b1;
      wait_reqs_done(20, "init_rd_timeout");
      check("init_rd_after", n_rgrant, 1);
      pulse_rvalid(1);

      // reset during beat 2 of an 8-beat write with reads outstanding
      clear_stats();
      start_rd(24'h080000, 4'd2, 4'd2);
      wait_reqs_done(20, "rst_rd_timeout");
      clear_stats();
      start_wr(24'h081000, 4'd8, 4'd8);
      for (int n = 0; n < 10 && n_ack < 2; n++) tick();
      rst_n = 1'b0;
      bus.wr_req = 1'b0;
      exp_wq.delete();
      bus.local_rdata_valid = 1'b1;
      bus.local_rdata = {32'($urandom), 32'($urandom)};
      tick();
      bus.local_rdata_valid = 1'b0;
      #1;
      check("mid_rst_state", bus.dbg_state, IDLE);
      check("mid_rst_reqs", {bus.local_write_req, bus.local_read_req, bus.local_burstbegin}, 3'b000);
      check("mid_rst_ack", bus.wr_data_ack, 1'b0);
      check("mid_rst_rd_out", bus.dbg_rd_out, 4'd0);
      rst_n = 1'b1;
      pulse_rvalid(2);
      check("post_rst_no_underflow", bus.dbg_rd_out, 4'd0);
      check("post_rst_idle", bus.dbg_state, IDLE);

      check("sb_wr_left", exp_wq.size(), 0);
      check("sb_rd_left", exp_rq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
